// File: rtl/register_file_mp.sv
// register_file_mp: multi-port integer register file with busy scoreboard.
// Combinational reads with write-through bypass; synchronous writes.
module register_file_mp #(
   parameter int XLEN     = 32,
   parameter int DEPTH    = 32,
   parameter int AW       = $clog2(DEPTH),
   parameter int NRD      = 2,
   parameter int NWR      = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                alloc_en,
   input  logic [AW-1:0]       alloc_addr
);

   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   logic [XLEN-1:0]  regs [DEPTH];
   logic [DEPTH-1:0] busy;

   // Register 0 (when hardwired) and out-of-range entries hold no state.
   function automatic logic valid(input logic [AW-1:0] a);
      return ({1'b0, a} < DEPTH_L) && !(ZERO_REG != 0 && a == '0);
   endfunction

   // Ascending port order lets the highest write port win; alloc last so set wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++)
            regs[i] <= '0;
         busy <= '0;
      end else begin
         for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && valid(wr_addr[w*AW +: AW])) begin
               regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
               busy[wr_addr[w*AW +: AW]] <= 1'b0;
            end
         end
         if (alloc_en && valid(alloc_addr))
            busy[alloc_addr] <= 1'b1;
      end
   end

   always_comb begin
      logic [AW-1:0] a;
      a       = '0;
      rd_data = '0;
      rd_busy = '0;
      for (int r = 0; r < NRD; r++) begin
         a = rd_addr[r*AW +: AW];
         if (valid(a)) begin
            rd_data[r*XLEN +: XLEN] = regs[a];
            rd_busy[r]              = busy[a];
            for (int w = 0; w < NWR; w++) begin
               if (reset_n && wr_en[w] && wr_addr[w*AW +: AW] == a) begin
                  rd_data[r*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
                  rd_busy[r]              = 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed and random checks of register_file_mp
// against an array-based reference model.
module tb_register_file_mp;

   localparam int XLEN  = 32;
   localparam int DEPTH = 32;
   localparam int AW    = 5;
   localparam int NRD   = 4;
   localparam int NWR   = 2;

   logic                clk;
   logic                reset_n;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic                alloc_en;
   logic [AW-1:0]       alloc_addr;

   int total = 0;
   int bad   = 0;

   logic [XLEN-1:0] mdl   [DEPTH];
   logic            mbusy [DEPTH];

   register_file_mp #(
      .XLEN(XLEN), .DEPTH(DEPTH), .AW(AW),
      .NRD(NRD), .NWR(NWR), .ZERO_REG(1)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                      input logic [XLEN-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) begin
         mdl[i]   = '0;
         mbusy[i] = 1'b0;
      end
   endtask

   // Value a reader should see right now, from the architectural rules.
   function automatic logic [XLEN-1:0] exp_data(input int r);
      int a;
      a = int'(rd_addr[r*AW +: AW]);
      if (!reset_n || a == 0) return '0;
      for (int w = NWR - 1; w >= 0; w--)
         if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a)
            return wr_data[w*XLEN +: XLEN];
      return mdl[a];
   endfunction

   function automatic logic exp_busy(input int r);
      int a;
      a = int'(rd_addr[r*AW +: AW]);
      if (!reset_n || a == 0) return 1'b0;
      for (int w = 0; w < NWR; w++)
         if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) return 1'b0;
      return mbusy[a];
   endfunction

   task automatic check_all(input string tag);
      for (int r = 0; r < NRD; r++) begin
         chk($sformatf("%s.data%0d", tag, r),
             rd_data[r*XLEN +: XLEN], exp_data(r));
         chk($sformatf("%s.busy%0d", tag, r),
             XLEN'(rd_busy[r]), XLEN'(exp_busy(r)));
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (reset_n) begin
         for (int w = 0; w < NWR; w++) begin
            int a;
            a = int'(wr_addr[w*AW +: AW]);
            if (wr_en[w] && a != 0) begin
               mdl[a]   = wr_data[w*XLEN +: XLEN];
               mbusy[a] = 1'b0;
            end
         end
         if (alloc_en && alloc_addr != 0) mbusy[int'(alloc_addr)] = 1'b1;
      end
      #2;
   endtask

   task automatic set_rd(input int r, input int a);
      rd_addr[r*AW +: AW] = AW'(a);
   endtask

   task automatic set_wr(input int w, input logic en, input int a,
                         input logic [XLEN-1:0] d);
      wr_en[w]               = en;
      wr_addr[w*AW +: AW]    = AW'(a);
      wr_data[w*XLEN +: XLEN] = d;
   endtask

   task automatic idle();
      wr_en    = '0;
      alloc_en = 1'b0;
   endtask

   initial begin
      reset_n    = 1'b0;
      rd_addr    = '0;
      wr_en      = '0;
      wr_addr    = '0;
      wr_data    = '0;
      alloc_en   = 1'b0;
      alloc_addr = '0;
      clear_model();
      for (int r = 0; r < NRD; r++) set_rd(r, r + 1);
      #12;
      check_all("reset_state");
      step();
      reset_n = 1'b1;
      step();

      // Reset mid-cycle discards stored data and busy bits.
      set_wr(0, 1'b1, 5, 32'hDEADBEEF);
      alloc_en   = 1'b1;
      alloc_addr = 5;
      set_rd(0, 5);
      step();
      idle();
      #1;
      chk("rst.pre_data", rd_data[0 +: XLEN], 32'hDEADBEEF);
      chk("rst.pre_busy", XLEN'(rd_busy[0]), 1);
      set_wr(1, 1'b1, 5, 32'h11111111);
      #1;
      reset_n = 1'b0;
      clear_model();
      #1;
      chk("rst.data", rd_data[0 +: XLEN], 0);
      chk("rst.busy", XLEN'(rd_busy[0]), 0);
      step();
      check_all("rst.held");
      idle();
      #2;
      reset_n = 1'b1;
      #1;
      check_all("rst.release");

      // Zero register ignores writes and allocations.
      step();
      set_wr(0, 1'b1, 0, 32'h12345678);
      alloc_en   = 1'b1;
      alloc_addr = 0;
      set_rd(0, 0);
      #1;
      chk("zero.same_data", rd_data[0 +: XLEN], 0);
      chk("zero.same_busy", XLEN'(rd_busy[0]), 0);
      step();
      idle();
      #1;
      chk("zero.next_data", rd_data[0 +: XLEN], 0);
      chk("zero.next_busy", XLEN'(rd_busy[0]), 0);

      // Write-through bypass.
      set_wr(0, 1'b1, 7, 32'hA5A5A5A5);
      set_rd(1, 7);
      #1;
      chk("bypass.same", rd_data[1*XLEN +: XLEN], 32'hA5A5A5A5);
      step();
      idle();
      #1;
      chk("bypass.stored", rd_data[1*XLEN +: XLEN], 32'hA5A5A5A5);

      // Write-port conflict: port 1 wins.
      set_wr(0, 1'b1, 9, 32'd1);
      set_wr(1, 1'b1, 9, 32'd2);
      set_rd(2, 9);
      #1;
      chk("conflict.bypass", rd_data[2*XLEN +: XLEN], 32'd2);
      step();
      idle();
      #1;
      chk("conflict.stored", rd_data[2*XLEN +: XLEN], 32'd2);

      // Scoreboard: allocate, write+alloc (set wins), write alone.
      set_rd(3, 3);
      alloc_en   = 1'b1;
      alloc_addr = 3;
      #1;
      chk("sb.alloc_same", XLEN'(rd_busy[3]), 0);
      step();
      idle();
      #1;
      chk("sb.alloc_next", XLEN'(rd_busy[3]), 1);
      set_wr(0, 1'b1, 3, 32'h33);
      alloc_en   = 1'b1;
      alloc_addr = 3;
      #1;
      chk("sb.mask", XLEN'(rd_busy[3]), 0);
      step();
      idle();
      #1;
      chk("sb.set_wins", XLEN'(rd_busy[3]), 1);
      set_wr(1, 1'b1, 3, 32'h44);
      #1;
      chk("sb.rel_mask", XLEN'(rd_busy[3]), 0);
      step();
      idle();
      #1;
      chk("sb.released", XLEN'(rd_busy[3]), 0);
      chk("sb.data", rd_data[3*XLEN +: XLEN], 32'h44);

      // Fill regs 1..31 with i*3, two per cycle.
      for (int i = 1; i < DEPTH; i += 2) begin
         set_wr(0, 1'b1, i, XLEN'(i * 3));
         if (i + 1 < DEPTH) set_wr(1, 1'b1, i + 1, XLEN'((i + 1) * 3));
         else wr_en[1] = 1'b0;
         step();
      end
      idle();
      #1;
      for (int n = 0; n < 100; n++) begin
         int pick [NRD];
         for (int r = 0; r < NRD; r++) begin
            logic dup;
            do begin
               pick[r] = int'($urandom_range(DEPTH - 1, 0));
               dup = 1'b0;
               for (int k = 0; k < r; k++)
                  if (pick[k] == pick[r]) dup = 1'b1;
            end while (dup);
            set_rd(r, pick[r]);
         end
         #1;
         for (int r = 0; r < NRD; r++)
            chk($sformatf("allports.%0d.p%0d", n, r),
                rd_data[r*XLEN +: XLEN], XLEN'(pick[r] * 3));
         step();
      end

      // Random mixed traffic against the model.
      for (int n = 0; n < 150; n++) begin
         for (int w = 0; w < NWR; w++)
            set_wr(w, 1'($urandom_range(1, 0)),
                   int'($urandom_range(DEPTH - 1, 0)), $urandom);
         alloc_en   = 1'($urandom_range(1, 0));
         alloc_addr = AW'($urandom_range(DEPTH - 1, 0));
         for (int r = 0; r < NRD; r++) begin
            if ($urandom_range(1, 0) == 1 && r < NWR)
               set_rd(r, int'(wr_addr[r*AW +: AW]));
            else
               set_rd(r, int'($urandom_range(DEPTH - 1, 0)));
         end
         #1;
         check_all($sformatf("rand.%0d", n));
         step();
      end
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port integer register file with an integrated busy scoreboard, the successor to the single-write, dual-read register file of the RV32 core. It provides `NRD` combinational read ports and `NWR` synchronous write ports, and forwards same-cycle writes to the read ports. It tracks one busy bit per register so the issue stage can detect pending producers. It sits between decode/issue (read and allocate) and writeback (write and release). All architectural state clears on reset.

## Interface
- `XLEN`, 32, data width.
- `DEPTH`, 32, number of registers.
- `AW`, `$clog2(DEPTH)`, address width.
- `NRD`, 2, read ports (1..4).
- `NWR`, 1, write ports (1..2).
- `ZERO_REG`, 1, when 1, register 0 reads 0 and ignores writes and allocations.

Ports:
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `rd_addr` input NRD*AW: read address, port r at `[r*AW +: AW]`.
- `rd_data` output NRD*XLEN: read data, port r at `[r*XLEN +: XLEN]`.
- `rd_busy` output NRD: busy bit of the addressed register, per port.
- `wr_en` input NWR: write enable, per port.
- `wr_addr` input NWR*AW: write address.
- `wr_data` input NWR*XLEN: write data.
- `alloc_en` input 1: mark `alloc_addr` busy (destination issued).
- `alloc_addr` input AW: register to mark busy.

## Operation
- **Storage.** `DEPTH` x `XLEN` registers plus a `DEPTH`-bit busy vector.
- **Write.** On each rising edge, for every w with `wr_en[w]`, the register at `wr_addr[w]` takes `wr_data[w]`.
  - Same-address conflict between write ports: the highest port index wins.
  - Addresses >= `DEPTH` are ignored.
- **Read.** Purely combinational.
  - If a port w has `wr_en[w]` set and `wr_addr[w] == rd_addr[r]` this cycle, `rd_data[r]` returns that port's `wr_data` (highest w on a tie). This is the write-through bypass.
  - Otherwise it returns the stored value.
  - Register 0 with `ZERO_REG=1` always reads 0, with no bypass.
  - Out-of-range addresses read 0.
- **Scoreboard.** The busy vector is updated on each rising edge:
  - A write to address a clears `busy[a]`.
  - `alloc_en` sets `busy[alloc_addr]`.
  - Allocate and write to the same address in the same cycle: **set wins**, because the new producer supersedes the completing one.
  - With `ZERO_REG=1`, `busy[0]` stays 0.
- **`rd_busy[r]`.** Equals `busy[rd_addr[r]]`, masked to 0 when a write to that address is bypassed this cycle (the value is available now).
  - It is not masked by a same-cycle allocation; the allocation takes effect from the next cycle.
- **Reset.** While `reset_n` is 0:
  - All registers are 0 and all busy bits are 0.
  - Writes and allocations are ignored and the bypass is disabled.
  - Consequently `rd_data` = 0 and `rd_busy` = 0 for every port.
  - Reset asserted mid-write discards that write.

## Timing
- Read latency: 0 cycles (combinational from `rd_addr`, `wr_*`, and state).
- Write latency: data is visible from storage on the cycle after the edge, and visible via bypass in the same cycle.
- Allocation: `rd_busy` rises on the cycle after the `alloc_en` edge.
- Release: `rd_busy` falls in the same cycle as the write (via the mask), and the stored busy bit is clear from the next cycle.
- Reset deassertion: state is 0; the first rising edge with `reset_n`=1 accepts writes.
  - No synchronizer is inside this block; `reset_n` deassertion is synchronised upstream.
- No stall or handshake. Every edge accepts all enabled operations.

## Test plan
1. **Reset.**
   - Stimulus: write `0xDEADBEEF` to reg 5, then pulse `reset_n` low asynchronously mid-cycle.
   - Required: reading reg 5 returns 0 immediately, and `rd_busy` is 0.
2. **Zero register.**
   - Stimulus: write `0x12345678` to reg 0 and allocate reg 0.
   - Required: `rd_data` for reg 0 stays 0 in the same and next cycles, and `rd_busy` stays 0.
3. **Bypass.**
   - Stimulus: in a single cycle, write `0xA5A5A5A5` to reg 7 with read port 1 addressing reg 7.
   - Required: port 1 reads `0xA5A5A5A5` that cycle, and storage holds the value next cycle.
4. **Write-port conflict (`NWR`=2).**
   - Stimulus: port 0 writes 1 and port 1 writes 2 to reg 9 in the same cycle.
   - Required: the bypass and the stored value are both 2.
5. **Scoreboard.**
   - Stimulus: allocate reg 3 (busy next cycle), then in a later cycle write reg 3 and allocate reg 3 together.
   - Required: `rd_busy` reads 0 in the write cycle (bypass mask) and 1 the following cycle (set wins).
   - Stimulus: a write alone.
   - Required: busy is cleared.
6. **All ports (`NRD`=4).**
   - Stimulus: fill regs 1..31 with value i*3, then read four distinct addresses each cycle for 100 random cycles.
   - Required: every port returns addr*3, with no cross-port interference.
